// File: rtl/cache_control_nway_if.sv
// CPU/datapath-facing bundle for the N-way cache controller.
// The controller attaches through the slave modport; the driving side uses master.
interface cache_control_nway_if #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned WAY_W = $clog2(WAYS)
);
   logic             mem_read;
   logic             mem_write;
   logic             pmem_resp;
   logic [WAYS-1:0]  hit_way;
   logic [WAYS-1:0]  valid_way;
   logic [WAYS-1:0]  dirty_way;
   logic [WAY_W-1:0] lru_way;

   logic             mem_resp;
   logic             pmem_read;
   logic             pmem_write;
   logic             pmem_addr_sel;
   logic             data_in_sel;
   logic             dirty_in;
   logic [WAY_W-1:0] way_sel;
   logic [1:0]       data_we_sel;
   logic [WAYS-1:0]  load_valid;
   logic [WAYS-1:0]  load_tag;
   logic [WAYS-1:0]  load_dirty;
   logic             lru_update;
   logic [WAY_W-1:0] lru_way_used;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;
   logic [CNT_W-1:0] wb_count;

   modport master (
      output mem_read, mem_write, pmem_resp, hit_way, valid_way, dirty_way, lru_way,
      input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, dirty_in,
             way_sel, data_we_sel, load_valid, load_tag, load_dirty, lru_update,
             lru_way_used, hit_count, miss_count, wb_count
   );

   modport slave (
      input  mem_read, mem_write, pmem_resp, hit_way, valid_way, dirty_way, lru_way,
      output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel, dirty_in,
             way_sel, data_we_sel, load_valid, load_tag, load_dirty, lru_update,
             lru_way_used, hit_count, miss_count, wb_count
   );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back cache controller: hit/miss FSM, victim
// selection (invalid first, then PLRU), and saturating performance counters.
module cache_control_nway #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   cache_control_nway_if.slave bus
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   typedef enum logic [1:0] {
      ACCESS,
      WRITE_BACK,
      ALLOCATE
   } state_t;

   state_t           state_q, state_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic             miss_pending_q, miss_pending_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

   logic             req, is_write, hit;
   logic [WAY_W-1:0] hit_idx, inv_idx, victim_sel;
   logic             hit_found, inv_found, victim_dirty;
   logic             hit_inc, miss_inc, wb_inc;
   logic [WAYS-1:0]  ld_valid, ld_tag, ld_dirty;
   logic [1:0]       we_sel;

   assign req      = bus.mem_read | bus.mem_write;
   assign is_write = bus.mem_write & ~bus.mem_read;
   assign hit      = |bus.hit_way;

   always_comb begin
      hit_idx   = '0;
      hit_found = 1'b0;
      inv_idx   = '0;
      inv_found = 1'b0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (bus.hit_way[i] && !hit_found) begin
            hit_idx   = WAY_W'(i);
            hit_found = 1'b1;
         end
         if (!bus.valid_way[i] && !inv_found) begin
            inv_idx   = WAY_W'(i);
            inv_found = 1'b1;
         end
      end
   end

   assign victim_sel   = inv_found ? inv_idx : bus.lru_way;
   assign victim_dirty = bus.valid_way[victim_sel] & bus.dirty_way[victim_sel];

   always_comb begin
      state_d            = state_q;
      victim_d           = victim_q;
      miss_pending_d     = miss_pending_q;
      hit_inc            = 1'b0;
      miss_inc           = 1'b0;
      wb_inc             = 1'b0;
      bus.mem_resp       = 1'b0;
      bus.pmem_read      = 1'b0;
      bus.pmem_write     = 1'b0;
      bus.pmem_addr_sel  = 1'b0;
      bus.data_in_sel    = 1'b0;
      bus.dirty_in       = 1'b0;
      bus.way_sel        = '0;
      bus.lru_update     = 1'b0;
      bus.lru_way_used   = '0;
      we_sel             = 2'b00;
      ld_valid           = '0;
      ld_tag             = '0;
      ld_dirty           = '0;

      case (state_q)
         ACCESS: begin
            if (req && hit) begin
               bus.mem_resp     = 1'b1;
               bus.way_sel      = hit_idx;
               bus.lru_update   = 1'b1;
               bus.lru_way_used = hit_idx;
               hit_inc          = ~miss_pending_q;
               miss_pending_d   = 1'b0;
               if (is_write) begin
                  we_sel       = 2'b01;
                  ld_dirty     = WAYS'(1) << hit_idx;
                  bus.dirty_in = 1'b1;
               end
            end else if (req) begin
               victim_d       = victim_sel;
               state_d        = victim_dirty ? WRITE_BACK : ALLOCATE;
               miss_pending_d = 1'b1;
               miss_inc       = 1'b1;
            end
         end
         WRITE_BACK: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = 1'b1;
            bus.way_sel       = victim_q;
            if (bus.pmem_resp) begin
               wb_inc  = 1'b1;
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            bus.pmem_read   = 1'b1;
            bus.way_sel     = victim_q;
            bus.data_in_sel = 1'b1;
            if (bus.pmem_resp) begin
               we_sel   = 2'b10;
               ld_valid = WAYS'(1) << victim_q;
               ld_tag   = WAYS'(1) << victim_q;
               ld_dirty = WAYS'(1) << victim_q;
               state_d  = ACCESS;
               // Abandoned request: nothing will re-access, so drop the pending flag now.
               if (!req) miss_pending_d = 1'b0;
            end
         end
         default: state_d = ACCESS;
      endcase
   end

   // Array writes are suppressed while reset is sampled so an abandoned refill leaves no partial line.
   assign bus.load_valid  = rst ? '0 : ld_valid;
   assign bus.load_tag    = rst ? '0 : ld_tag;
   assign bus.load_dirty  = rst ? '0 : ld_dirty;
   assign bus.data_we_sel = rst ? 2'b00 : we_sel;

   assign hit_cnt_d  = (hit_inc  && hit_cnt_q  != '1) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
   assign miss_cnt_d = (miss_inc && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
   assign wb_cnt_d   = (wb_inc   && wb_cnt_q   != '1) ? wb_cnt_q   + CNT_W'(1) : wb_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ACCESS;
         victim_q       <= '0;
         miss_pending_q <= 1'b0;
         hit_cnt_q      <= '0;
         miss_cnt_q     <= '0;
         wb_cnt_q       <= '0;
      end else begin
         state_q        <= state_d;
         victim_q       <= victim_d;
         miss_pending_q <= miss_pending_d;
         hit_cnt_q      <= hit_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         wb_cnt_q       <= wb_cnt_d;
      end
   end

   assign bus.hit_count  = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
   assign bus.wb_count   = wb_cnt_q;

   a_no_dual_req: assert property (@(posedge clk) disable iff (rst)
      !(bus.mem_read && bus.mem_write));
   a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
      (state_q == ACCESS && req) |-> $onehot0(bus.hit_way));
endmodule

// File: tb/tb_cache_control_nway.sv
// Directed self-checking bench for cache_control_nway (WAYS=4; a second
// instance with CNT_W=2 exercises counter saturation).
module tb_cache_control_nway;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cache_control_nway_if #(.WAYS(4), .CNT_W(16)) bus_a ();
   cache_control_nway_if #(.WAYS(4), .CNT_W(2))  bus_b ();

   cache_control_nway #(.WAYS(4), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   cache_control_nway #(.WAYS(4), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.pmem_resp = 0;
      bus_a.hit_way = '0; bus_a.valid_way = '0; bus_a.dirty_way = '0; bus_a.lru_way = '0;
      bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.pmem_resp = 0;
      bus_b.hit_way = '0; bus_b.valid_way = '0; bus_b.dirty_way = '0; bus_b.lru_way = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      step();
      step();
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus_a.mem_resp, bus_a.pmem_read, bus_a.pmem_write, bus_a.pmem_addr_sel,
           bus_a.data_in_sel, bus_a.dirty_in, bus_a.lru_update} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0", {bus_a.mem_resp, bus_a.pmem_read,
            bus_a.pmem_write, bus_a.pmem_addr_sel, bus_a.data_in_sel, bus_a.dirty_in, bus_a.lru_update});
      end
      checks++;
      if ({bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel, bus_a.way_sel} !== '0) begin
         errors++; $display("FAIL reset_loads got %h exp 0",
            {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel, bus_a.way_sel});
      end
      checks++;
      if ({bus_a.hit_count, bus_a.miss_count, bus_a.wb_count} !== '0) begin
         errors++; $display("FAIL reset_counters got %h exp 0",
            {bus_a.hit_count, bus_a.miss_count, bus_a.wb_count});
      end
   endtask

   task automatic test_read_hit();
      do_reset();
      bus_a.mem_read = 1; bus_a.hit_way = 4'b0100; bus_a.valid_way = 4'b1111;
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b1) begin errors++; $display("FAIL rd_hit_resp got %b exp 1", bus_a.mem_resp); end
      checks++;
      if (bus_a.way_sel !== 2'd2 || bus_a.lru_way_used !== 2'd2 || bus_a.lru_update !== 1'b1) begin
         errors++; $display("FAIL rd_hit_way got way_sel=%0d lru_used=%0d upd=%b exp 2 2 1",
            bus_a.way_sel, bus_a.lru_way_used, bus_a.lru_update);
      end
      checks++;
      if ({bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel} !== '0) begin
         errors++; $display("FAIL rd_hit_noload got %h exp 0",
            {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel});
      end
      step();
      checks++;
      if (bus_a.hit_count !== 16'd1) begin errors++; $display("FAIL rd_hit_count got %0d exp 1", bus_a.hit_count); end
      set_idle();
   endtask

   task automatic test_write_hit();
      do_reset();
      bus_a.mem_write = 1; bus_a.hit_way = 4'b0001; bus_a.valid_way = 4'b1111;
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b1 || bus_a.data_we_sel !== 2'b01 || bus_a.data_in_sel !== 1'b0) begin
         errors++; $display("FAIL wr_hit_ctrl got resp=%b we=%b din=%b exp 1 01 0",
            bus_a.mem_resp, bus_a.data_we_sel, bus_a.data_in_sel);
      end
      checks++;
      if (bus_a.load_dirty !== 4'b0001 || bus_a.dirty_in !== 1'b1 || bus_a.load_valid !== 4'b0000) begin
         errors++; $display("FAIL wr_hit_dirty got ld_dirty=%b dirty_in=%b ld_valid=%b exp 0001 1 0000",
            bus_a.load_dirty, bus_a.dirty_in, bus_a.load_valid);
      end
      step();
      checks++;
      if (bus_a.hit_count !== 16'd1) begin errors++; $display("FAIL wr_hit_count got %0d exp 1", bus_a.hit_count); end
      set_idle();
   endtask

   task automatic test_clean_miss();
      do_reset();
      bus_a.mem_read = 1; bus_a.valid_way = 4'b1011; bus_a.lru_way = 2'd0;
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b0 || bus_a.pmem_read !== 1'b0) begin
         errors++; $display("FAIL miss_c1 got resp=%b pread=%b exp 0 0", bus_a.mem_resp, bus_a.pmem_read);
      end
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 5) begin bus_a.pmem_resp = 1; #1; end
         checks++;
         if (bus_a.pmem_read !== 1'b1 || bus_a.pmem_write !== 1'b0 || bus_a.way_sel !== 2'd2 ||
             bus_a.data_in_sel !== 1'b1 || bus_a.pmem_addr_sel !== 1'b0 || bus_a.mem_resp !== 1'b0) begin
            errors++; $display("FAIL miss_alloc%0d got pr=%b pw=%b way=%0d din=%b asel=%b resp=%b exp 1 0 2 1 0 0",
               k, bus_a.pmem_read, bus_a.pmem_write, bus_a.way_sel, bus_a.data_in_sel,
               bus_a.pmem_addr_sel, bus_a.mem_resp);
         end
         checks++;
         if (k < 5 && {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel} !== '0) begin
            errors++; $display("FAIL miss_early_load%0d got %h exp 0", k,
               {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel});
         end else if (k == 5 && {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel,
                      bus_a.dirty_in} !== {4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b0}) begin
            errors++; $display("FAIL miss_refill_load got v=%b t=%b d=%b we=%b din=%b exp 0100 0100 0100 10 0",
               bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel, bus_a.dirty_in);
         end
      end
      step();
      bus_a.pmem_resp = 0; bus_a.hit_way = 4'b0100; bus_a.valid_way = 4'b1111;
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b1 || bus_a.pmem_read !== 1'b0) begin
         errors++; $display("FAIL miss_resp_c7 got resp=%b pread=%b exp 1 0", bus_a.mem_resp, bus_a.pmem_read);
      end
      step();
      set_idle();
      checks++;
      if (bus_a.miss_count !== 16'd1 || bus_a.hit_count !== 16'd0 || bus_a.wb_count !== 16'd0) begin
         errors++; $display("FAIL miss_counts got m=%0d h=%0d wb=%0d exp 1 0 0",
            bus_a.miss_count, bus_a.hit_count, bus_a.wb_count);
      end
   endtask

   task automatic test_dirty_miss();
      do_reset();
      bus_a.mem_read = 1; bus_a.valid_way = 4'b1111; bus_a.dirty_way = 4'b1000; bus_a.lru_way = 2'd3;
      for (int k = 1; k <= 2; k++) begin
         step();
         if (k == 2) begin bus_a.pmem_resp = 1; #1; end
         checks++;
         if (bus_a.pmem_write !== 1'b1 || bus_a.pmem_read !== 1'b0 || bus_a.pmem_addr_sel !== 1'b1 ||
             bus_a.way_sel !== 2'd3 || bus_a.load_valid !== 4'b0) begin
            errors++; $display("FAIL wb_cycle%0d got pw=%b pr=%b asel=%b way=%0d ldv=%b exp 1 0 1 3 0000",
               k, bus_a.pmem_write, bus_a.pmem_read, bus_a.pmem_addr_sel, bus_a.way_sel, bus_a.load_valid);
         end
      end
      step();
      bus_a.pmem_resp = 0;
      #1;
      checks++;
      if (bus_a.pmem_read !== 1'b1 || bus_a.pmem_write !== 1'b0 || bus_a.pmem_addr_sel !== 1'b0 ||
          bus_a.way_sel !== 2'd3) begin
         errors++; $display("FAIL wb_alloc got pr=%b pw=%b asel=%b way=%0d exp 1 0 0 3",
            bus_a.pmem_read, bus_a.pmem_write, bus_a.pmem_addr_sel, bus_a.way_sel);
      end
      checks++;
      if (bus_a.wb_count !== 16'd1) begin errors++; $display("FAIL wb_count got %0d exp 1", bus_a.wb_count); end
      bus_a.pmem_resp = 1;
      #1;
      checks++;
      if (bus_a.load_valid !== 4'b1000 || bus_a.load_tag !== 4'b1000 || bus_a.load_dirty !== 4'b1000 ||
          bus_a.dirty_in !== 1'b0) begin
         errors++; $display("FAIL wb_refill got v=%b t=%b d=%b din=%b exp 1000 1000 1000 0",
            bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.dirty_in);
      end
      step();
      bus_a.pmem_resp = 0; bus_a.hit_way = 4'b1000; bus_a.dirty_way = 4'b0000;
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b1 || bus_a.way_sel !== 2'd3) begin
         errors++; $display("FAIL wb_resp got resp=%b way=%0d exp 1 3", bus_a.mem_resp, bus_a.way_sel);
      end
      step();
      set_idle();
      checks++;
      if (bus_a.miss_count !== 16'd1 || bus_a.hit_count !== 16'd0 || bus_a.wb_count !== 16'd1) begin
         errors++; $display("FAIL wb_counts got m=%0d h=%0d wb=%0d exp 1 0 1",
            bus_a.miss_count, bus_a.hit_count, bus_a.wb_count);
      end
   endtask

   task automatic test_reset_mid_alloc();
      do_reset();
      bus_a.mem_read = 1; bus_a.valid_way = 4'b0000;
      step();
      step();
      checks++;
      if (bus_a.pmem_read !== 1'b1 || bus_a.miss_count !== 16'd1) begin
         errors++; $display("FAIL rstmid_pre got pr=%b m=%0d exp 1 1", bus_a.pmem_read, bus_a.miss_count);
      end
      rst = 1; bus_a.pmem_resp = 1;
      #1;
      checks++;
      if ({bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel} !== '0) begin
         errors++; $display("FAIL rstmid_partial_load got %h exp 0",
            {bus_a.load_valid, bus_a.load_tag, bus_a.load_dirty, bus_a.data_we_sel});
      end
      step();
      rst = 0; set_idle();
      #1;
      checks++;
      if (bus_a.pmem_read !== 1'b0 || bus_a.pmem_write !== 1'b0 || bus_a.load_valid !== 4'b0 ||
          {bus_a.hit_count, bus_a.miss_count, bus_a.wb_count} !== '0) begin
         errors++; $display("FAIL rstmid_after got pr=%b pw=%b ldv=%b m=%0d exp 0 0 0000 0",
            bus_a.pmem_read, bus_a.pmem_write, bus_a.load_valid, bus_a.miss_count);
      end
   endtask

   task automatic test_drop_mid_miss();
      do_reset();
      bus_a.mem_read = 1; bus_a.valid_way = 4'b0111; bus_a.lru_way = 2'd1;
      step();
      bus_a.mem_read = 0; bus_a.pmem_resp = 1;
      #1;
      checks++;
      if (bus_a.load_valid !== 4'b1000 || bus_a.pmem_read !== 1'b1) begin
         errors++; $display("FAIL drop_refill got ldv=%b pr=%b exp 1000 1", bus_a.load_valid, bus_a.pmem_read);
      end
      step();
      #1;
      checks++;
      if (bus_a.mem_resp !== 1'b0 || bus_a.pmem_read !== 1'b0 || bus_a.load_valid !== 4'b0) begin
         errors++; $display("FAIL drop_idle got resp=%b pr=%b ldv=%b exp 0 0 0000",
            bus_a.mem_resp, bus_a.pmem_read, bus_a.load_valid);
      end
      step();
      bus_a.pmem_resp = 0;
      checks++;
      if (bus_a.pmem_read !== 1'b0 || bus_a.pmem_write !== 1'b0 || bus_a.miss_count !== 16'd1) begin
         errors++; $display("FAIL access_pmem_resp_ignored got pr=%b pw=%b m=%0d exp 0 0 1",
            bus_a.pmem_read, bus_a.pmem_write, bus_a.miss_count);
      end
      bus_a.mem_read = 1; bus_a.hit_way = 4'b0001; bus_a.valid_way = 4'b1111;
      step();
      set_idle();
      checks++;
      if (bus_a.hit_count !== 16'd1) begin
         errors++; $display("FAIL drop_pending_cleared got hit_count=%0d exp 1", bus_a.hit_count);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      bus_b.mem_read = 1; bus_b.hit_way = 4'b0010; bus_b.valid_way = 4'b1111;
      step();
      step();
      checks++;
      if (bus_b.hit_count !== 2'd2) begin errors++; $display("FAIL sat_two got %0d exp 2", bus_b.hit_count); end
      step();
      step();
      step();
      checks++;
      if (bus_b.hit_count !== 2'd3 || bus_b.mem_resp !== 1'b1) begin
         errors++; $display("FAIL sat_hold got cnt=%0d resp=%b exp 3 1", bus_b.hit_count, bus_b.mem_resp);
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      #1;
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_reset_mid_alloc();
      test_drop_mid_miss();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
